// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB types, port/buffer sizing and requester identifiers.
package cdb_arbiter_pkg;

   localparam int CDB_NUM_PORTS = 2;
   localparam int CDB_BUF_DEPTH = 2;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      MUL = 3'd1,
      DIV = 3'd2,
      BR  = 3'd3,
      MEM = 3'd4
   } cdb_src_e;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rob_idx;
      logic [5:0]  pd;
      logic [4:0]  rd;
      logic [31:0] rd_v;
   } cdb_t;

   localparam int CDB_NUM_SRC = int'(MEM) + 1;

endpackage

// File: rtl/cdb_req_fifo.sv
// cdb_req_fifo: per-requester result buffer; a flush empties it and drops any same-cycle push.
module cdb_req_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter  int DEPTH = CDB_BUF_DEPTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  cdb_t          din,
   output cdb_t          head,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   cdb_t          mem [DEPTH];
   logic [PW-1:0] rptr;
   logic [PW-1:0] wptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = count == '0;
   assign full    = count == CW'(DEPTH);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign head    = mem[rptr];

   always_ff @(posedge clk)
      if (do_push) mem[wptr] <= din;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         count <= '0;
         rptr  <= '0;
         wptr  <= '0;
      end else if (flush) begin
         count <= '0;
         rptr  <= '0;
         wptr  <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop) rptr <= rptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers FU results per requester and round-robin drains up to NUM_CDB
// buffer heads per cycle onto the common data bus ports.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter  int NUM_REQ   = CDB_NUM_SRC,
   parameter  int NUM_CDB   = CDB_NUM_PORTS,
   parameter  int BUF_DEPTH = CDB_BUF_DEPTH,
   localparam int SW        = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
   localparam int CW        = $clog2(BUF_DEPTH) + 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  cdb_t [NUM_REQ-1:0]              req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output cdb_t [NUM_CDB-1:0]              cdb_out,
   output logic [NUM_CDB-1:0][SW-1:0]      grant_src
);

   cdb_t [NUM_REQ-1:0]          head;
   logic [NUM_REQ-1:0][CW-1:0]  count;
   logic [NUM_REQ-1:0]          empty;
   logic [NUM_REQ-1:0]          full;
   logic [NUM_REQ-1:0]          pop;
   logic [SW-1:0]               rr_ptr;
   logic [SW-1:0]               rr_next;
   int                          pos  [NUM_REQ];
   int                          rank [NUM_REQ];
   int                          last_pos;
   int                          nxt;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
      cdb_req_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .flush (flush),
         .push  (req_valid[i]),
         .pop   (pop[i]),
         .din   (req_data[i]),
         .head  (head[i]),
         .count (count[i]),
         .empty (empty[i]),
         .full  (full[i])
      );
      // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
      assign req_ready[i] = (count[i] < CW'(BUF_DEPTH)) && !flush;
      a_full_not_ready: assert property (@(posedge clk) disable iff (!rst_n) full[i] |-> !req_ready[i]);
   end

   // pos = scan distance from rr_ptr; rank = non-empty buffers ahead in scan order = port index.
   always_comb begin
      cdb_out   = '0;
      grant_src = '0;
      pop       = '0;
      last_pos  = -1;
      for (int i = 0; i < NUM_REQ; i++)
         pos[i] = i >= int'(rr_ptr) ? i - int'(rr_ptr) : i - int'(rr_ptr) + NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
         rank[i] = 0;
         for (int m = 0; m < NUM_REQ; m++)
            rank[i] = rank[i] + ((!empty[m] && pos[m] < pos[i]) ? 1 : 0);
      end
      for (int i = 0; i < NUM_REQ; i++)
         if (!flush && !empty[i] && rank[i] < NUM_CDB) begin
            pop[i]   = 1'b1;
            last_pos = pos[i] > last_pos ? pos[i] : last_pos;
            for (int k = 0; k < NUM_CDB; k++)
               if (rank[i] == k) begin
                  cdb_out[k]       = head[i];
                  cdb_out[k].valid = 1'b1;
                  grant_src[k]     = SW'(i);
               end
         end
      nxt     = int'(rr_ptr) + last_pos + 1;
      nxt     = nxt >= NUM_REQ ? nxt - NUM_REQ : nxt;
      rr_next = last_pos < 0 ? rr_ptr : SW'(nxt);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rr_ptr <= '0;
      else rr_ptr <= flush ? '0 : rr_next;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios for cdb_arbiter at NUM_REQ=5, NUM_CDB=2, BUF_DEPTH=2.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int NR = 5;
   localparam int NC = 2;
   localparam int SW = 3;

   logic                    clk       = 1'b0;
   logic                    rst_n     = 1'b0;
   logic                    flush     = 1'b0;
   logic [NR-1:0]           req_valid = '0;
   cdb_t [NR-1:0]           req_data  = '0;
   logic [NR-1:0]           req_ready;
   cdb_t [NC-1:0]           cdb_out;
   logic [NC-1:0][SW-1:0]   grant_src;
   int                      checks    = 0;
   int                      errors    = 0;

   always #5 clk = ~clk;

   cdb_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .cdb_out   (cdb_out),
      .grant_src (grant_src)
   );

   function automatic cdb_t mk(input logic [31:0] v, input logic [4:0] rob);
      cdb_t c;
      c         = '0;
      c.rd_v    = v;
      c.rob_idx = rob;
      c.rd      = v[4:0];
      c.pd      = v[5:0];
      return c;
   endfunction

   function automatic cdb_t ex(input logic [31:0] v, input logic [4:0] rob);
      cdb_t c;
      c       = mk(v, rob);
      c.valid = 1'b1;
      return c;
   endfunction

   task automatic step;
      @(negedge clk);
      req_valid = '0;
      flush     = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      #1;
      checks++; if (cdb_out !== '0) begin errors++; $display("FAIL reset_cdb: got %h want 0", cdb_out); end
      checks++; if (grant_src !== '0) begin errors++; $display("FAIL reset_grant: got %h want 0", grant_src); end
      step;
      rst_n = 1'b1;
      #1;
      checks++; if (req_ready !== 5'b11111) begin errors++; $display("FAIL reset_ready: got %b want 11111", req_ready); end
      checks++; if (cdb_out !== '0) begin errors++; $display("FAIL reset_cdb_rel: got %h want 0", cdb_out); end
   endtask

   task automatic test_single_push;
      step;
      req_valid[0] = 1'b1;
      req_data[0]  = mk(32'h11, 5'd3);
      #1;
      checks++; if (cdb_out[0].valid !== 1'b0) begin errors++; $display("FAIL sp_no_bypass: got %b want 0", cdb_out[0].valid); end
      step;
      #1;
      checks++; if (cdb_out[0] !== ex(32'h11, 5'd3)) begin errors++; $display("FAIL sp_port0: got %h want %h", cdb_out[0], ex(32'h11, 5'd3)); end
      checks++; if (grant_src[0] !== 3'd0) begin errors++; $display("FAIL sp_grant0: got %0d want 0", grant_src[0]); end
      checks++; if (cdb_out[1] !== '0) begin errors++; $display("FAIL sp_port1: got %h want 0", cdb_out[1]); end
      step;
      #1;
      checks++; if (cdb_out !== '0) begin errors++; $display("FAIL sp_empty: got %h want 0", cdb_out); end
      checks++; if (req_ready !== 5'b11111) begin errors++; $display("FAIL sp_ready: got %b want 11111", req_ready); end
   endtask

   task automatic test_contention;
      step;
      flush = 1'b1;
      step;
      req_valid = 5'b11111;
      for (int i = 0; i < NR; i++) req_data[i] = mk(32'(32'h20 + i), 5'(i));
      step;
      #1;
      checks++; if (cdb_out[0] !== ex(32'h20, 5'd0)) begin errors++; $display("FAIL ct_c1_p0: got %h want %h", cdb_out[0], ex(32'h20, 5'd0)); end
      checks++; if (cdb_out[1] !== ex(32'h21, 5'd1)) begin errors++; $display("FAIL ct_c1_p1: got %h want %h", cdb_out[1], ex(32'h21, 5'd1)); end
      checks++; if (grant_src !== {3'd1, 3'd0}) begin errors++; $display("FAIL ct_c1_grant: got %h want %h", grant_src, {3'd1, 3'd0}); end
      step;
      #1;
      checks++; if (cdb_out[0] !== ex(32'h22, 5'd2)) begin errors++; $display("FAIL ct_c2_p0: got %h want %h", cdb_out[0], ex(32'h22, 5'd2)); end
      checks++; if (cdb_out[1] !== ex(32'h23, 5'd3)) begin errors++; $display("FAIL ct_c2_p1: got %h want %h", cdb_out[1], ex(32'h23, 5'd3)); end
      checks++; if (grant_src !== {3'd3, 3'd2}) begin errors++; $display("FAIL ct_c2_grant: got %h want %h", grant_src, {3'd3, 3'd2}); end
      step;
      #1;
      checks++; if (cdb_out[0] !== ex(32'h24, 5'd4)) begin errors++; $display("FAIL ct_c3_p0: got %h want %h", cdb_out[0], ex(32'h24, 5'd4)); end
      checks++; if (cdb_out[1] !== '0) begin errors++; $display("FAIL ct_c3_p1: got %h want 0", cdb_out[1]); end
      checks++; if (grant_src !== {3'd0, 3'd4}) begin errors++; $display("FAIL ct_c3_grant: got %h want %h", grant_src, {3'd0, 3'd4}); end
      step;
      req_valid   = 5'b10001;
      req_data[0] = mk(32'h30, 5'd5);
      req_data[4] = mk(32'h34, 5'd6);
      step;
      #1;
      checks++; if (cdb_out[0] !== ex(32'h30, 5'd5)) begin errors++; $display("FAIL ct_rr0_p0: got %h want %h", cdb_out[0], ex(32'h30, 5'd5)); end
      checks++; if (cdb_out[1] !== ex(32'h34, 5'd6)) begin errors++; $display("FAIL ct_rr0_p1: got %h want %h", cdb_out[1], ex(32'h34, 5'd6)); end
      checks++; if (grant_src !== {3'd4, 3'd0}) begin errors++; $display("FAIL ct_rr0_grant: got %h want %h", grant_src, {3'd4, 3'd0}); end
   endtask

   task automatic test_backpressure;
      step;
      req_valid   = 5'b01100;
      req_data[2] = mk(32'h40, 5'd1);
      req_data[3] = mk(32'h41, 5'd2);
      step;
      req_valid   = 5'b10011;
      req_data[4] = mk(32'h42, 5'd3);
      req_data[0] = mk(32'h43, 5'd4);
      req_data[1] = mk(32'h50, 5'd7);
      #1;
      checks++; if (grant_src !== {3'd3, 3'd2}) begin errors++; $display("FAIL bp_pre_grant: got %h want %h", grant_src, {3'd3, 3'd2}); end
      checks++; if (cdb_out[0] !== ex(32'h40, 5'd1)) begin errors++; $display("FAIL bp_pre_p0: got %h want %h", cdb_out[0], ex(32'h40, 5'd1)); end
      step;
      req_valid[1] = 1'b1;
      req_data[1]  = mk(32'h51, 5'd8);
      #1;
      checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL bp_ready_c1: got %b want 1", req_ready[1]); end
      checks++; if (cdb_out[0] !== ex(32'h42, 5'd3)) begin errors++; $display("FAIL bp_busy_p0: got %h want %h", cdb_out[0], ex(32'h42, 5'd3)); end
      checks++; if (cdb_out[1] !== ex(32'h43, 5'd4)) begin errors++; $display("FAIL bp_busy_p1: got %h want %h", cdb_out[1], ex(32'h43, 5'd4)); end
      checks++; if (grant_src !== {3'd0, 3'd4}) begin errors++; $display("FAIL bp_busy_grant: got %h want %h", grant_src, {3'd0, 3'd4}); end
      step;
      req_valid[1] = 1'b1;
      req_data[1]  = mk(32'h52, 5'd9);
      #1;
      checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", req_ready[1]); end
      checks++; if (cdb_out[0] !== ex(32'h50, 5'd7)) begin errors++; $display("FAIL bp_first: got %h want %h", cdb_out[0], ex(32'h50, 5'd7)); end
      checks++; if (grant_src[0] !== 3'd1) begin errors++; $display("FAIL bp_first_src: got %0d want 1", grant_src[0]); end
      checks++; if (cdb_out[1] !== '0) begin errors++; $display("FAIL bp_first_p1: got %h want 0", cdb_out[1]); end
      step;
      #1;
      checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL bp_ready_c3: got %b want 1", req_ready[1]); end
      checks++; if (cdb_out[0] !== ex(32'h51, 5'd8)) begin errors++; $display("FAIL bp_second: got %h want %h", cdb_out[0], ex(32'h51, 5'd8)); end
      step;
      #1;
      checks++; if (cdb_out !== '0) begin errors++; $display("FAIL bp_dropped: got %h want 0", cdb_out); end
   endtask

   task automatic test_back_to_back;
      for (int k = 1; k <= 7; k++) begin
         step;
         if (k <= 6) begin
            req_valid[0] = 1'b1;
            req_data[0]  = mk(32'(k), 5'(k));
         end
         #1;
         checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL wrap_ready_%0d: got %b want 1", k, req_ready[0]); end
         if (k >= 2) begin
            checks++; if (cdb_out[0] !== ex(32'(k - 1), 5'(k - 1))) begin errors++; $display("FAIL wrap_out_%0d: got %h want %h", k, cdb_out[0], ex(32'(k - 1), 5'(k - 1))); end
         end
      end
      step;
      #1;
      checks++; if (cdb_out !== '0) begin errors++; $display("FAIL wrap_empty: got %h want 0", cdb_out); end
   endtask

   task automatic test_flush;
      step;
      req_valid   = 5'b01101;
      req_data[0] = mk(32'h60, 5'd1);
      req_data[2] = mk(32'h62, 5'd2);
      req_data[3] = mk(32'h63, 5'd3);
      step;
      flush       = 1'b1;
      req_valid   = 5'b01000;
      req_data[3] = mk(32'h64, 5'd4);
      #1;
      checks++; if (cdb_out !== '0) begin errors++; $display("FAIL fl_out: got %h want 0", cdb_out); end
      checks++; if (grant_src !== '0) begin errors++; $display("FAIL fl_grant: got %h want 0", grant_src); end
      checks++; if (req_ready !== 5'b00000) begin errors++; $display("FAIL fl_ready: got %b want 00000", req_ready); end
      step;
      #1;
      checks++; if (cdb_out !== '0) begin errors++; $display("FAIL fl_after: got %h want 0", cdb_out); end
      checks++; if (req_ready !== 5'b11111) begin errors++; $display("FAIL fl_after_ready: got %b want 11111", req_ready); end
      step;
      req_valid   = 5'b10001;
      req_data[0] = mk(32'h70, 5'd5);
      req_data[4] = mk(32'h74, 5'd6);
      step;
      #1;
      checks++; if (cdb_out[0] !== ex(32'h70, 5'd5)) begin errors++; $display("FAIL fl_rr_p0: got %h want %h", cdb_out[0], ex(32'h70, 5'd5)); end
      checks++; if (cdb_out[1] !== ex(32'h74, 5'd6)) begin errors++; $display("FAIL fl_rr_p1: got %h want %h", cdb_out[1], ex(32'h74, 5'd6)); end
      step;
      #1;
      checks++; if (cdb_out !== '0) begin errors++; $display("FAIL fl_no_br: got %h want 0", cdb_out); end
   endtask

   task automatic test_async_reset;
      step;
      req_valid   = 5'b00110;
      req_data[1] = mk(32'h80, 5'd1);
      req_data[2] = mk(32'h82, 5'd2);
      step;
      #1;
      checks++; if (cdb_out[0] !== ex(32'h80, 5'd1)) begin errors++; $display("FAIL ar_pre: got %h want %h", cdb_out[0], ex(32'h80, 5'd1)); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (cdb_out !== '0) begin errors++; $display("FAIL ar_out: got %h want 0", cdb_out); end
      checks++; if (grant_src !== '0) begin errors++; $display("FAIL ar_grant: got %h want 0", grant_src); end
      step;
      rst_n        = 1'b1;
      req_valid[0] = 1'b1;
      req_data[0]  = mk(32'h11, 5'd3);
      #1;
      checks++; if (cdb_out !== '0) begin errors++; $display("FAIL ar_lost: got %h want 0", cdb_out); end
      step;
      #1;
      checks++; if (cdb_out[0] !== ex(32'h11, 5'd3)) begin errors++; $display("FAIL ar_sp_p0: got %h want %h", cdb_out[0], ex(32'h11, 5'd3)); end
      checks++; if (grant_src[0] !== 3'd0) begin errors++; $display("FAIL ar_sp_src: got %0d want 0", grant_src[0]); end
      checks++; if (cdb_out[1] !== '0) begin errors++; $display("FAIL ar_sp_p1: got %h want 0", cdb_out[1]); end
      step;
      #1;
      checks++; if (cdb_out !== '0) begin errors++; $display("FAIL ar_sp_empty: got %h want 0", cdb_out); end
   endtask

   initial begin
      test_reset;
      test_single_push;
      test_contention;
      test_backpressure;
      test_back_to_back;
      test_flush;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
